// File: rtl/onehot_phase_monitor.sv
// Checks a rotating one-hot counter state and reports phase, revolution count and faults.
// Define ONEHOT_PHASE_MONITOR_AUTORECOVER_EN to let ERROR recover after three clean samples.
module onehot_phase_monitor #(
    parameter int N    = 3,
    parameter int PW   = 2,
    parameter int CYCW = 8
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [N-1:0]    onehot_in,
    input  logic            clear,
    output logic [PW-1:0]   phase,
    output logic            phase_valid,
    output logic            wrap_pulse,
    output logic [CYCW-1:0] cycle_count,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t          state, state_nxt;
    logic [N-1:0]    prev, prev_nxt;
    logic [PW-1:0]   phase_nxt;
    logic            wrap_nxt;
    logic [CYCW-1:0] count_nxt;
    logic            legal, advance, stall;
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
    logic [1:0]      rec_cnt, rec_cnt_nxt;
    logic            rec_step, rec_done;
`endif

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

    function automatic logic [PW-1:0] index_of(input logic [N-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = PW'(i);
        end
        return r;
    endfunction

    assign legal   = is_onehot(onehot_in);
    assign advance = (onehot_in == rotl(prev));
    assign stall   = (onehot_in == prev);
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
    // In ERROR, prev holds the last legal sample of the recovery run instead.
    assign rec_step = legal && (rec_cnt != 2'd0) && advance;
    assign rec_done = rec_step && (rec_cnt == 2'd2);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            prev        <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
            cycle_count <= '0;
            err         <= 1'b0;
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
            rec_cnt     <= 2'd0;
`endif
        end else begin
            state       <= state_nxt;
            prev        <= prev_nxt;
            phase       <= phase_nxt;
            phase_valid <= (state_nxt == TRACK);
            wrap_pulse  <= wrap_nxt;
            cycle_count <= count_nxt;
            err         <= (state_nxt == ERROR);
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
            rec_cnt     <= rec_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (legal) state_nxt = TRACK;
                TRACK:   if (!advance && !stall) state_nxt = ERROR;
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
                ERROR:   if (rec_done) state_nxt = TRACK;
`endif
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        prev_nxt  = prev;
        phase_nxt = phase;
        wrap_nxt  = 1'b0;
        count_nxt = cycle_count;
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
        rec_cnt_nxt = rec_cnt;
`endif
        if (clear) begin
            prev_nxt  = '0;
            count_nxt = '0;
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
            rec_cnt_nxt = 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (legal) begin
                        prev_nxt  = onehot_in;
                        phase_nxt = index_of(onehot_in);
                    end
                end
                TRACK: begin
                    if (advance) begin
                        prev_nxt  = onehot_in;
                        phase_nxt = index_of(onehot_in);
                        if (prev[N-1]) begin
                            wrap_nxt  = 1'b1;
                            count_nxt = cycle_count + CYCW'(1);
                        end
                    end
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
                    else if (!stall) begin
                        rec_cnt_nxt = 2'd0;
                    end
`endif
                end
`ifdef ONEHOT_PHASE_MONITOR_AUTORECOVER_EN
                // Wraps seen while recovering are deliberately not counted.
                ERROR: begin
                    if (!legal) begin
                        rec_cnt_nxt = 2'd0;
                    end else if (rec_done) begin
                        prev_nxt    = onehot_in;
                        phase_nxt   = index_of(onehot_in);
                        rec_cnt_nxt = 2'd0;
                    end else if (rec_step) begin
                        prev_nxt    = onehot_in;
                        rec_cnt_nxt = rec_cnt + 2'd1;
                    end else begin
                        prev_nxt    = onehot_in;
                        rec_cnt_nxt = 2'd1;
                    end
                end
`endif
                default: begin
                    prev_nxt = prev;
                end
            endcase
        end
    end
endmodule
